matvec_fetch_ctrl: RTL and testbench

Avalon-MM read master and FIFO loader for the 8x8 matrix-vector engine. On `start` it reads eight 64-bit A-row words and one 64-bit B-vector word from on-chip memory. It unpacks each word into bytes and pushes them into the per-row A FIFOs and the shared B FIFO, then raises `done` so the top-level FSM can move from FETCH to COMPUTE. It sits between the memory wrapper and the FIFO/MAC array, and its state encoding drives the `mem_ctrl_state` debug view.

---
 rtl/matvec_pkg.sv | 20 ++
 rtl/word_unpacker.sv | 40 ++++
 rtl/matvec_fetch_ctrl.sv | 150 +++++++++++++++
 tb/tb_matvec_fetch_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matvec_pkg.sv
// Shared encodings and sizing for the matrix-vector engine fetch path.
// The fetch FSM encoding is also what the debug view and the bench decode.
package matvec_pkg;

    localparam int unsigned NUM_ROWS   = 8;
    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned BUS_WIDTH  = NUM_ROWS * DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH_A = 3'd1,
        WAIT_A  = 3'd2,
        WRITE_A = 3'd3,
        FETCH_B = 3'd4,
        WAIT_B  = 3'd5,
        WRITE_B = 3'd6,
        DONE    = 3'd7
    } fetch_state_t;

endpackage

// File: rtl/word_unpacker.sv
// Holds one bus word and presents it a byte at a time, most significant byte first.
// The byte index advances only on cycles that are enabled and not stalled.
module word_unpacker #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_BYTES  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load,
    input  logic [NUM_BYTES*DATA_WIDTH-1:0] load_data,
    input  logic                            advance,
    input  logic                            stall,
    output logic [DATA_WIDTH-1:0]           byte_out,
    output logic                            last
);

    localparam int unsigned BUS_W = NUM_BYTES * DATA_WIDTH;
    localparam int unsigned IDX_W = $clog2(NUM_BYTES);

    logic [BUS_W-1:0] word_q;
    logic [IDX_W-1:0] idx_q;

    // Shift the consumed byte out so the current byte always sits in the top lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (load) begin
            word_q <= load_data;
            idx_q  <= '0;
        end else if (advance && !stall) begin
            word_q <= word_q << DATA_WIDTH;
            idx_q  <= idx_q + IDX_W'(1);
        end
    end

    assign byte_out = word_q[BUS_W-1 -: DATA_WIDTH];
    assign last     = (idx_q == IDX_W'(NUM_BYTES - 1));

endmodule

// File: rtl/matvec_fetch_ctrl.sv
// Avalon-MM read master that fetches the A rows and the B vector and
// unpacks each word into the per-row A FIFOs and the shared B FIFO.
module matvec_fetch_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_ROWS   = 8,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned A_BASE     = 0,
    parameter int unsigned B_ADDR     = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic [2:0]                     state_dbg,
    output logic [ADDR_WIDTH-1:0]          avm_address,
    output logic                           avm_read,
    input  logic [NUM_ROWS*DATA_WIDTH-1:0] avm_readdata,
    input  logic                           avm_readdatavalid,
    input  logic                           avm_waitrequest,
    output logic [NUM_ROWS-1:0]            fifo_a_wren,
    output logic [DATA_WIDTH-1:0]          fifo_a_wdata,
    input  logic [NUM_ROWS-1:0]            fifo_a_full,
    output logic                           fifo_b_wren,
    output logic [DATA_WIDTH-1:0]          fifo_b_wdata,
    input  logic                           fifo_b_full
);

    import matvec_pkg::*;

    localparam int unsigned ROW_W = $clog2(NUM_ROWS);

    fetch_state_t           state_q, state_nxt;
    logic [ROW_W-1:0]       row_q, row_nxt;
    logic                   unpack_load;
    logic                   unpack_adv;
    logic                   unpack_stall;
    logic [DATA_WIDTH-1:0]  unpack_byte;
    logic                   unpack_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
        end else begin
            state_q <= state_nxt;
            row_q   <= row_nxt;
        end
    end

    // Next state and outputs; every output depends only on registered state,
    // the row counter and (for write enables) the FIFO full flags.
    always_comb begin
        state_nxt    = state_q;
        row_nxt      = row_q;
        unpack_load  = 1'b0;
        unpack_adv   = 1'b0;
        unpack_stall = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        avm_read     = 1'b0;
        avm_address  = '0;
        fifo_a_wren  = '0;
        fifo_b_wren  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                busy = 1'b0;
                done = (state_q == DONE);
                if (start) begin
                    state_nxt = FETCH_A;
                    row_nxt   = '0;
                end
            end
            FETCH_A: begin
                avm_read    = 1'b1;
                avm_address = ADDR_WIDTH'(A_BASE) + ADDR_WIDTH'(row_q);
                if (!avm_waitrequest) begin
                    state_nxt = WAIT_A;
                end
            end
            WAIT_A: begin
                if (avm_readdatavalid) begin
                    unpack_load = 1'b1;
                    state_nxt   = WRITE_A;
                end
            end
            WRITE_A: begin
                unpack_adv   = 1'b1;
                unpack_stall = fifo_a_full[row_q];
                if (!fifo_a_full[row_q]) begin
                    fifo_a_wren = NUM_ROWS'(1) << row_q;
                    if (unpack_last) begin
                        if (row_q == ROW_W'(NUM_ROWS - 1)) begin
                            state_nxt = FETCH_B;
                        end else begin
                            row_nxt   = row_q + ROW_W'(1);
                            state_nxt = FETCH_A;
                        end
                    end
                end
            end
            FETCH_B: begin
                avm_read    = 1'b1;
                avm_address = ADDR_WIDTH'(B_ADDR);
                if (!avm_waitrequest) begin
                    state_nxt = WAIT_B;
                end
            end
            WAIT_B: begin
                if (avm_readdatavalid) begin
                    unpack_load = 1'b1;
                    state_nxt   = WRITE_B;
                end
            end
            WRITE_B: begin
                unpack_adv   = 1'b1;
                unpack_stall = fifo_b_full;
                if (!fifo_b_full) begin
                    fifo_b_wren = 1'b1;
                    if (unpack_last) begin
                        state_nxt = DONE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    word_unpacker #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_BYTES  (NUM_ROWS)
    ) u_unpacker (
        .clk       (clk),
        .rst       (rst),
        .load      (unpack_load),
        .load_data (avm_readdata),
        .advance   (unpack_adv),
        .stall     (unpack_stall),
        .byte_out  (unpack_byte),
        .last      (unpack_last)
    );

    assign state_dbg    = state_q;
    assign fifo_a_wdata = unpack_byte;
    assign fifo_b_wdata = unpack_byte;

endmodule

// File: tb/tb_matvec_fetch_ctrl.sv
// Self-checking bench for matvec_fetch_ctrl: Avalon memory responder,
// FIFO write monitor against a byte scoreboard, and per-scenario tasks.
module tb_matvec_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [2:0]  state_dbg;
    logic [31:0] avm_address;
    logic        avm_read;
    logic [63:0] avm_readdata;
    logic        avm_readdatavalid;
    logic        avm_waitrequest;
    logic [7:0]  fifo_a_wren;
    logic [7:0]  fifo_a_wdata;
    logic [7:0]  fifo_a_full;
    logic        fifo_b_wren;
    logic [7:0]  fifo_b_wdata;
    logic        fifo_b_full;

    always #5 clk = ~clk;

    matvec_fetch_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .busy              (busy),
        .done              (done),
        .state_dbg         (state_dbg),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .avm_waitrequest   (avm_waitrequest),
        .fifo_a_wren       (fifo_a_wren),
        .fifo_a_wdata      (fifo_a_wdata),
        .fifo_a_full       (fifo_a_full),
        .fifo_b_wren       (fifo_b_wren),
        .fifo_b_wdata      (fifo_b_wdata),
        .fifo_b_full       (fifo_b_full)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] mem [0:8];
    logic [10:0] exp_a [$];
    logic [7:0]  exp_b [$];
    logic [31:0] exp_addr [$];

    logic [31:0] ws_addr = 32'hFFFF_FFFF;
    int          ws_n = 0;
    int          ws_used = 0;
    int          ws_addr_cycles = 0;
    int          full_row = -1;
    int          full_after = 0;
    int          full_len = 0;
    int          full_left = 0;
    bit          full_done = 0;
    int          a_wr_cnt [8];
    int          b_wr_cnt = 0;
    bit          stray_pulse = 0;
    bit          acc_pend = 0;
    logic [31:0] acc_addr = '0;
    int          outstanding = 0;

    // Memory responder and FIFO monitor, both sampled mid-cycle.
    initial begin : responder
        int          r;
        logic [10:0] ea;
        logic [7:0]  eb;
        logic [31:0] ead;
        avm_readdatavalid = 1'b0;
        avm_waitrequest   = 1'b0;
        avm_readdata      = '0;
        forever begin
            @(negedge clk);
            if (fifo_a_wren != 8'h00) begin
                r = 0;
                for (int i = 0; i < 8; i++) if (fifo_a_wren[i]) r = i;
                n_tests++;
                if (!$onehot(fifo_a_wren) || (fifo_a_wren & fifo_a_full) != 8'h00 || exp_a.size() == 0) begin
                    n_fail++;
                    $display("FAIL a_write_legal: wren=%b full=%b pending=%0d", fifo_a_wren, fifo_a_full, exp_a.size());
                end else begin
                    ea = exp_a.pop_front();
                    if ({3'(r), fifo_a_wdata} !== ea) begin
                        n_fail++;
                        $display("FAIL a_fifo_data: got row%0d=%h expected row%0d=%h", r, fifo_a_wdata, ea[10:8], ea[7:0]);
                    end
                end
                a_wr_cnt[r]++;
            end
            if (fifo_b_wren) begin
                n_tests++;
                if (fifo_b_full || exp_b.size() == 0) begin
                    n_fail++;
                    $display("FAIL b_write_legal: full=%b pending=%0d", fifo_b_full, exp_b.size());
                end else begin
                    eb = exp_b.pop_front();
                    if (fifo_b_wdata !== eb) begin
                        n_fail++;
                        $display("FAIL b_fifo_data: got %h expected %h", fifo_b_wdata, eb);
                    end
                end
                b_wr_cnt++;
            end
            if (rst) begin
                acc_pend          = 0;
                outstanding       = 0;
                avm_readdatavalid = 1'b0;
                avm_waitrequest   = 1'b0;
            end else begin
                if (acc_pend) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = mem[acc_addr[3:0]];
                    acc_pend          = 0;
                    outstanding--;
                end else if (stray_pulse) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = 64'hDEAD_BEEF_CAFE_F00D;
                    stray_pulse       = 0;
                end else begin
                    avm_readdatavalid = 1'b0;
                end
                avm_waitrequest = 1'b0;
                if (avm_read) begin
                    if (avm_address == ws_addr) ws_addr_cycles++;
                    if (avm_address == ws_addr && ws_used < ws_n) begin
                        avm_waitrequest = 1'b1;
                        ws_used++;
                    end else begin
                        n_tests++;
                        if (outstanding != 0) begin
                            n_fail++;
                            $display("FAIL one_outstanding: got %0d outstanding expected 0", outstanding);
                        end
                        n_tests++;
                        if (exp_addr.size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_read: got address %0d expected no read", avm_address);
                        end else begin
                            ead = exp_addr.pop_front();
                            if (avm_address !== ead) begin
                                n_fail++;
                                $display("FAIL read_address: got %0d expected %0d", avm_address, ead);
                            end
                        end
                        acc_pend = 1;
                        acc_addr = avm_address;
                        outstanding++;
                    end
                end
            end
        end
    end

    // Full-flag driver, changed just after the active edge so each write is seen whole.
    initial begin : full_driver
        fifo_a_full = '0;
        fifo_b_full = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (full_left > 0) begin
                full_left--;
                if (full_left == 0) fifo_a_full[full_row] = 1'b0;
            end else if (full_row >= 0 && !full_done && a_wr_cnt[full_row] == full_after) begin
                fifo_a_full[full_row] = 1'b1;
                full_left = full_len;
                full_done = 1;
            end
        end
    end

    task automatic fill_pattern();
        for (int r = 0; r < 9; r++)
            for (int k = 1; k <= 8; k++)
                mem[r][64-8*k +: 8] = {4'(r), 4'(k)};
    endtask

    task automatic load_expectations();
        exp_a.delete();
        exp_b.delete();
        exp_addr.delete();
        for (int r = 0; r < 8; r++) begin
            exp_addr.push_back(32'(r));
            for (int k = 0; k < 8; k++) exp_a.push_back({3'(r), mem[r][56-8*k +: 8]});
            a_wr_cnt[r] = 0;
        end
        exp_addr.push_back(32'd8);
        for (int k = 0; k < 8; k++) exp_b.push_back(mem[8][56-8*k +: 8]);
        b_wr_cnt       = 0;
        ws_used        = 0;
        ws_addr_cycles = 0;
        full_done      = 0;
    endtask

    task automatic run_fetch(input string name, input int exp_lat, input bit pulse_in_wait, input bit abort_in_wb);
        int t0;
        bit pend_pulse;
        load_expectations();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b1 || state_dbg !== 3'd1) begin
            n_fail++;
            $display("FAIL %s_accept: got done=%b busy=%b state=%0d expected 0 1 1", name, done, busy, state_dbg);
        end
        pend_pulse = pulse_in_wait;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (pend_pulse && state_dbg == 3'd2) begin
                start = 1'b1;
                pend_pulse = 0;
            end
            if (abort_in_wb && state_dbg == 3'd6 && b_wr_cnt >= 2) begin
                rst = 1'b1;
                #1;
                n_tests++;
                if (state_dbg !== 3'd0 || fifo_a_wren !== 8'h00 || fifo_b_wren !== 1'b0 || avm_read !== 1'b0 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_abort: got state=%0d awren=%b bwren=%b read=%b busy=%b expected all 0",
                             name, state_dbg, fifo_a_wren, fifo_b_wren, avm_read, busy);
                end
                @(negedge clk);
                rst = 1'b0;
                exp_b.delete();
                return;
            end
        end
        start = 1'b0;
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timeout: got done=%b expected 1 within 400 cycles", name, done);
        end else if (cyc - t0 != exp_lat) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles expected %0d", name, cyc - t0, exp_lat);
        end
        n_tests++;
        if (exp_a.size() != 0 || exp_b.size() != 0 || exp_addr.size() != 0) begin
            n_fail++;
            $display("FAIL %s_complete: got a=%0d b=%0d addr=%0d left expected 0 0 0",
                     name, exp_a.size(), exp_b.size(), exp_addr.size());
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (state_dbg !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || avm_read !== 1'b0 || avm_address !== 32'd0 ||
            fifo_a_wren !== 8'h00 || fifo_b_wren !== 1'b0 || fifo_a_wdata !== 8'h00 || fifo_b_wdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_values: got state=%0d busy=%b done=%b read=%b addr=%0h wren=%b/%b wdata=%h/%h expected all 0",
                     state_dbg, busy, done, avm_read, avm_address, fifo_a_wren, fifo_b_wren, fifo_a_wdata, fifo_b_wdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_stray_valid();
        exp_a.delete();
        exp_b.delete();
        exp_addr.delete();
        @(negedge clk);
        stray_pulse = 1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (state_dbg !== 3'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_valid: got state=%0d busy=%b expected 0 0", state_dbg, busy);
        end
    endtask

    task automatic test_nominal();
        fill_pattern();
        run_fetch("nominal", 90, 0, 0);
    endtask

    task automatic test_waitrequest();
        ws_addr = 32'd2;
        ws_n    = 3;
        run_fetch("waitreq", 93, 0, 0);
        n_tests++;
        if (ws_addr_cycles != 4) begin
            n_fail++;
            $display("FAIL waitreq_hold: got %0d read cycles at address 2 expected 4", ws_addr_cycles);
        end
        ws_n    = 0;
        ws_addr = 32'hFFFF_FFFF;
    endtask

    task automatic test_fifo_full();
        full_row   = 5;
        full_after = 3;
        full_len   = 4;
        run_fetch("fifo_full", 94, 0, 0);
        full_row = -1;
    endtask

    task automatic test_start_busy();
        run_fetch("start_busy", 90, 1, 0);
    endtask

    task automatic test_restart();
        repeat (3) @(negedge clk);
        n_tests++;
        if (done !== 1'b1 || state_dbg !== 3'd7) begin
            n_fail++;
            $display("FAIL done_hold: got done=%b state=%0d expected 1 7", done, state_dbg);
        end
        for (int r = 0; r < 9; r++) mem[r] = {$urandom, $urandom};
        run_fetch("restart", 90, 0, 0);
    endtask

    task automatic test_reset_mid_wb();
        fill_pattern();
        run_fetch("abort", 0, 0, 1);
        run_fetch("after_abort", 90, 0, 0);
    endtask

    initial begin
        test_reset();
        test_stray_valid();
        test_nominal();
        test_waitrequest();
        test_fifo_full();
        test_start_busy();
        test_restart();
        test_reset_mid_wb();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
